// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM fetch front end.
package arm_pipe_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] ARM_NOP = 32'hE1A0_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc4;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STALE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/arm_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-ROM req/ack, decode valid/ready and EX redirect.
interface arm_fetch_unit_if #(
    parameter int unsigned IMEM_AW = 8
);
    import arm_pipe_pkg::*;

    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [31:0]        id_pc4;
    logic               br_taken;
    logic [31:0]        br_target;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc4,
        input  imem_ack, imem_rdata, id_ready, br_taken, br_target
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc4,
        output imem_ack, imem_rdata, id_ready, br_taken, br_target
    );

endinterface

// File: rtl/arm_fetch_queue.sv
// Prefetch FIFO of {instr, pc4} entries; flush wins over push and pop.
module arm_fetch_queue
    import arm_pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_c;
    logic             do_pop_c;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign do_push_c = push_i && !flush_i && !full_o;
    assign do_pop_c  = pop_i && !flush_i && !empty_o;
    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_c) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        end
    end

endmodule

// File: rtl/arm_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs the ROM req/ack handshake and feeds
// decode from the prefetch queue; EX redirects flush the queue and squash in-flight fetches.
module arm_fetch_unit
    import arm_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned IMEM_AW     = 8,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    arm_fetch_unit_if.master fetch_if
);

    localparam int unsigned CNT_W   = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [1:0]  S_IDLE  = 2'(IDLE);
    localparam logic [1:0]  S_WAIT  = 2'(WAIT);
    localparam logic [1:0]  S_STALE = 2'(STALE);

    logic [1:0]         state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [IMEM_AW-1:0] addr_q, addr_d;
    logic               req_q, req_d;

    logic               ack_live_c;
    logic               push_c;
    logic               pop_c;
    logic [31:0]        pc_plus4_c;
    logic [CNT_W-1:0]   q_count;
    logic [CNT_W-1:0]   count_after_c;
    logic               q_empty;
    logic               q_full;
    fetch_entry_t       push_entry_c;
    fetch_entry_t       q_head;

    assign pc_plus4_c    = fetch_pc_q + 32'd4;
    assign ack_live_c    = fetch_if.imem_ack && (state_q == S_WAIT);
    assign push_c        = ack_live_c && !fetch_if.br_taken;
    assign pop_c         = fetch_if.id_ready && !q_empty;
    assign count_after_c = q_count + CNT_W'(push_c) - CNT_W'(pop_c);
    assign push_entry_c  = '{instr: fetch_if.imem_rdata, pc4: pc_plus4_c};

    arm_fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .Clk         (Clk),
        .Reset       (Reset),
        .push_i      (push_c),
        .push_data_i (push_entry_c),
        .pop_i       (pop_c),
        .flush_i     (fetch_if.br_taken),
        .head_o      (q_head),
        .count_o     (q_count),
        .empty_o     (q_empty),
        .full_o      (q_full)
    );

    // Only one request is ever outstanding, so "room for it" reduces to the queue count.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;

        if (fetch_if.br_taken) begin
            fetch_pc_d = fetch_if.br_target & 32'hFFFF_FFFC;
        end

        case (state_q)
            S_IDLE: begin
                if (!fetch_if.br_taken && !q_full) begin
                    state_d = S_WAIT;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q[IMEM_AW-1:0];
                end
            end
            S_WAIT: begin
                if (fetch_if.br_taken) begin
                    if (fetch_if.imem_ack) begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end else begin
                        state_d = S_STALE;
                    end
                end else if (fetch_if.imem_ack) begin
                    fetch_pc_d = pc_plus4_c;
                    if (count_after_c < CNT_W'(QUEUE_DEPTH)) begin
                        addr_d = pc_plus4_c[IMEM_AW-1:0];
                    end else begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            S_STALE: begin
                if (fetch_if.imem_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC[IMEM_AW-1:0];
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
        end
    end

    assign fetch_if.imem_req  = req_q;
    assign fetch_if.imem_addr = addr_q;
    assign fetch_if.id_valid  = !q_empty;
    assign fetch_if.id_instr  = q_head.instr;
    assign fetch_if.id_pc4    = q_head.pc4;

endmodule

// File: tb/tb_arm_fetch_unit.sv
// Bench for arm_fetch_unit: directed scenarios then random traffic, checked against a
// transaction-level model of the expected fetch and delivery streams.
module tb_arm_fetch_unit;
    import arm_pipe_pkg::*;

    localparam int unsigned AW     = 8;
    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;

    arm_fetch_unit_if #(.IMEM_AW(AW)) fif ();

    arm_fetch_unit #(
        .RESET_PC    (RST_PC),
        .IMEM_AW     (AW),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .fetch_if (fif.master)
    );

    always #5 Clk = ~Clk;

    int          n_err = 0;
    int          n_chk = 0;
    int          cnt_m;
    logic [31:0] exp_pc;
    logic [31:0] exp_req_pc;
    bit          squashed;
    int          rom_lat   = 0;
    int          wait_cnt  = 0;
    bit          rand_lat  = 1'b0;
    bit          force_ack = 1'b0;
    int          acks_acc  = 0;

    function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
        return {8'hE1, a, ~a, a ^ 8'h5A};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        cnt_m      = 0;
        exp_pc     = RST_PC;
        exp_req_pc = RST_PC;
        squashed   = 1'b0;
        wait_cnt   = 0;
    endtask

    // One clock: ROM answers, the edge happens, the model advances and the outputs are checked.
    task automatic tick();
        logic          rst_s, req_s, ack_s, br_s, val_s, rdy_s, acc;
        logic [AW-1:0] addr_s;
        logic [31:0]   tgt_s;
        fif.imem_ack   = force_ack || (fif.imem_req && wait_cnt >= rom_lat);
        fif.imem_rdata = fif.imem_req ? rom_word(fif.imem_addr) : 32'hDEAD_BEEF;
        rst_s  = Reset;
        req_s  = fif.imem_req;
        ack_s  = fif.imem_ack;
        br_s   = fif.br_taken;
        tgt_s  = fif.br_target;
        val_s  = fif.id_valid;
        rdy_s  = fif.id_ready;
        addr_s = fif.imem_addr;
        @(posedge Clk);
        @(negedge Clk);
        force_ack    = 1'b0;
        fif.imem_ack = 1'b0;
        wait_cnt = (req_s && !ack_s) ? wait_cnt + 1 : 0;
        if (ack_s && rand_lat) rom_lat = $urandom_range(0, 2);
        if (!rst_s) begin
            reset_model();
            return;
        end

        acc = ack_s && req_s && !squashed && !br_s;
        if (acc) begin
            chk("req_addr", 32'(addr_s), 32'(exp_req_pc[AW-1:0]));
            exp_req_pc = exp_req_pc + 32'd4;
            acks_acc++;
        end
        if (ack_s && req_s) squashed = 1'b0;
        if (br_s) begin
            if (req_s && !ack_s) squashed = 1'b1;
            cnt_m      = 0;
            exp_pc     = tgt_s & 32'hFFFF_FFFC;
            exp_req_pc = tgt_s & 32'hFFFF_FFFC;
        end else begin
            if (val_s && rdy_s) begin
                cnt_m--;
                exp_pc = exp_pc + 32'd4;
            end
            if (acc) cnt_m++;
        end

        chk("id_valid", 32'(fif.id_valid), 32'(cnt_m != 0));
        if (cnt_m != 0) begin
            chk("head_instr", fif.id_instr, rom_word(exp_pc[AW-1:0]));
            chk("head_pc4", fif.id_pc4, exp_pc + 32'd4);
        end
        if (req_s && !ack_s) begin
            chk("req_hold", 32'(fif.imem_req), 32'd1);
            chk("addr_hold", 32'(fif.imem_addr), 32'(addr_s));
        end
        if (fif.imem_req) chk("slot_reserve", 32'(cnt_m < int'(DEPTH)), 32'd1);
        if (acc) chk("req_after_ack", 32'(fif.imem_req), 32'(cnt_m < int'(DEPTH)));
        if (br_s && !req_s) chk("no_issue_on_br", 32'(fif.imem_req), 32'd0);
    endtask

    task automatic pulse_reset();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
    endtask

    initial begin
        fif.imem_ack   = 1'b0;
        fif.imem_rdata = '0;
        fif.id_ready   = 1'b0;
        fif.br_taken   = 1'b0;
        fif.br_target  = '0;
        reset_model();

        // Reset values
        @(negedge Clk);
        chk("rst_req", 32'(fif.imem_req), 32'd0);
        chk("rst_valid", 32'(fif.id_valid), 32'd0);
        chk("rst_instr", fif.id_instr, 32'd0);
        chk("rst_pc4", fif.id_pc4, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;

        // 1: back-to-back fetch with decode always ready
        fif.id_ready = 1'b1;
        tick();
        chk("t1_req", 32'(fif.imem_req), 32'd1);
        chk("t1_addr0", 32'(fif.imem_addr), 32'h00);
        tick();
        chk("t1_addr4", 32'(fif.imem_addr), 32'h04);
        chk("t1_pc4_4", fif.id_pc4, 32'd4);
        tick();
        chk("t1_addr8", 32'(fif.imem_addr), 32'h08);
        chk("t1_pc4_8", fif.id_pc4, 32'd8);
        repeat (8) tick();

        // 2: decode stall fills the queue, then the stream resumes
        pulse_reset();
        fif.id_ready = 1'b0;
        acks_acc = 0;
        repeat (10) tick();
        chk("t2_acks", 32'(acks_acc), 32'd4);
        chk("t2_req_drop", 32'(fif.imem_req), 32'd0);
        chk("t2_head_instr", fif.id_instr, rom_word(8'h00));
        chk("t2_head_pc4", fif.id_pc4, 32'd4);
        fif.id_ready = 1'b1;
        repeat (20) tick();

        // 3: redirect while a request is outstanding
        rom_lat = 3;
        for (int i = 0; i < 50 && !(fif.imem_req && !squashed); i++) tick();
        chk("t3_pre_req", 32'(fif.imem_req), 32'd1);
        fif.br_taken  = 1'b1;
        fif.br_target = 32'h0000_0042;
        tick();
        fif.br_taken = 1'b0;
        chk("t3_stale_req", 32'(fif.imem_req), 32'd1);
        rom_lat = 0;
        tick();
        for (int i = 0; i < 10 && !(fif.imem_req && !squashed); i++) tick();
        chk("t3_new_addr", 32'(fif.imem_addr), 32'h40);
        for (int i = 0; i < 10 && !fif.id_valid; i++) tick();
        chk("t3_first_pc4", fif.id_pc4, 32'h44);
        repeat (6) tick();

        // 4: redirect coinciding with an ack, two entries queued
        pulse_reset();
        fif.id_ready = 1'b0;
        repeat (3) tick();
        chk("t4_valid_pre", 32'(fif.id_valid), 32'd1);
        chk("t4_req_pre", 32'(fif.imem_req), 32'd1);
        fif.br_taken  = 1'b1;
        fif.br_target = 32'h0000_0080;
        tick();
        fif.br_taken = 1'b0;
        chk("t4_flushed", 32'(fif.id_valid), 32'd0);
        fif.id_ready = 1'b1;
        for (int i = 0; i < 10 && !fif.id_valid; i++) tick();
        chk("t4_first_pc4", fif.id_pc4, 32'h84);
        repeat (4) tick();

        // 5: fetch PC wraps past the top of the address space
        fif.br_taken  = 1'b1;
        fif.br_target = 32'hFFFF_FFFC;
        tick();
        fif.br_taken = 1'b0;
        for (int i = 0; i < 10 && !(fif.imem_req && !squashed); i++) tick();
        chk("t5_addr_fc", 32'(fif.imem_addr), 32'hFC);
        tick();
        chk("t5_addr_wrap", 32'(fif.imem_addr), 32'h00);
        chk("t5_valid", 32'(fif.id_valid), 32'd1);
        chk("t5_pc4_wrap", fif.id_pc4, 32'd0);
        chk("t5_instr", fif.id_instr, rom_word(8'hFC));
        repeat (4) tick();

        // 6: reset in WAIT with three entries queued, then a stray ack in IDLE
        pulse_reset();
        fif.id_ready = 1'b0;
        repeat (4) tick();
        chk("t6_req_pre", 32'(fif.imem_req), 32'd1);
        chk("t6_valid_pre", 32'(fif.id_valid), 32'd1);
        Reset = 1'b0;
        #1;
        chk("t6_req_async", 32'(fif.imem_req), 32'd0);
        chk("t6_valid_async", 32'(fif.id_valid), 32'd0);
        chk("t6_pc4_async", fif.id_pc4, 32'd0);
        tick();
        Reset     = 1'b1;
        force_ack = 1'b1;
        tick();
        chk("t6_req_after", 32'(fif.imem_req), 32'd1);
        chk("t6_addr_after", 32'(fif.imem_addr), 32'(RST_PC[AW-1:0]));
        tick();
        chk("t6_first_pc4", fif.id_pc4, RST_PC + 32'd4);

        // Random traffic: stalls, ROM latency and redirects
        pulse_reset();
        rand_lat = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            fif.id_ready = ($urandom_range(0, 99) < 70);
            fif.br_taken = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 3) == 0)
                fif.br_target = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            else
                fif.br_target = $urandom();
            tick();
        end
        fif.br_taken = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
